sw_alloc_rr: RTL and testbench
==============================

SW_ALLOC_RR -- requirements
Module: sw_alloc_rr

Interface
REQ-001 SHALL have parameter ALLOW_UTURN, default 0: 1 permits input p to request output p; 0 makes such requests illegal.
REQ-002 SHALL have parameter RR, default 1: 1 selects round-robin arbitration per output; 0 selects fixed priority, lowest index wins.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_req, input, [4:0][4:0]: in_req[p][o] means input p requests output o. Port index 0=S, 1=W, 2=N, 3=E, 4=L.
REQ-006 SHALL have port in_tail, input, [4:0]: one-cycle pulse meaning the tail flit of the packet on input p has been accepted by the crossbar.
REQ-007 SHALL have port in_gnt, output, [4:0]: level signal, input p currently owns an output.
REQ-008 SHALL have port out_cfg, output, [4:0][4:0]: out_cfg[o][p]=1 means crossbar output o is connected to input p; each out_cfg[o] is one-hot or zero.
REQ-009 SHALL have port err, output, [1:0]: sticky error flags. Bit0 = illegal U-turn request seen; bit1 = multi-hot request seen.

Function
REQ-010 SHALL implement one two-state FSM per output o: IDLE and LOCKED(owner).
REQ-011 Eligibility: input p is eligible for output o in a cycle only if in_req[p] is exactly one-hot at o, in_gnt[p]=0, and the request is legal.
REQ-012 IDLE -> LOCKED: if any input is eligible, the arbiter picks a winner. On the next edge out_cfg[o] and in_gnt[winner] assert, giving 1-cycle latency from request to grant.
REQ-013 RR=1: search starts at ptr[o] and goes upward modulo 5. ptr[o] resets to 0 and becomes owner+1 (mod 5, so 4 wraps to 0) on release.
REQ-014 LOCKED: out_cfg[o] and in_gnt[owner] stay constant regardless of in_req[owner]. A deasserted request does not release the lock (wormhole hold).
REQ-015 LOCKED -> IDLE: when in_tail[owner]=1, out_cfg[o] and in_gnt[owner] clear on the next edge.
REQ-016 The released output SHALL NOT arbitrate in the same cycle as the release. This forces exactly one idle bubble cycle before the next grant.
REQ-017 in_tail[p] while in_gnt[p]=0 SHALL be ignored, with no state change and no error.
REQ-018 Since requests are one-hot, an input SHALL never be granted more than one output. At most one bit set per in_req row is accepted.
REQ-019 Multi-hot in_req[p]: input p is ineligible for all outputs that cycle and err[1] sets.
REQ-020 Illegal U-turn (ALLOW_UTURN=0, in_req[p][p]=1): the request is ignored and err[0] sets.
REQ-021 A request withdrawn before it is granted SHALL simply drop out of arbitration, with no side effects.
REQ-022 Outputs SHALL arbitrate independently. Up to 5 grants can issue in the same cycle.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-024 With rst=1 at an edge: all FSMs go to IDLE, out_cfg=0, in_gnt=0, every ptr=0, err=0.
REQ-025 Reset SHALL override an in-progress lock. A packet mid-transfer loses its grant with no tail required.
REQ-026 The first grant after rst deasserts SHALL appear no earlier than one cycle after the first sampled request.

Verification
REQ-027 Single request: in_req[4]=5'b00001 (L->S) at cycle 0 -> out_cfg[0]=5'b10000 and in_gnt=5'b10000 at cycle 1. Pulse in_tail[4] at cycle 5 -> both clear at cycle 6.
REQ-028 RR contention: inputs 1, 2 and 3 all hold requests for output 4 (L) with ptr=0. Grants go to 1, then 2, then 3, with each grant following a tail and exactly one bubble cycle between grants.
REQ-029 Wormhole hold: after a grant to input 2 for output 0, drop in_req[2] for 3 cycles -> out_cfg[0] remains 5'b00100 until in_tail[2].
REQ-030 Errors: in_req[0]=5'b00001 with ALLOW_UTURN=0 -> no grant and err=2'b01. Then in_req[3]=5'b10010 -> no grant and err=2'b11; err persists until rst.
REQ-031 Parallel grants: in_req = {L->N, E->W, N->S, W->E, S->L} in the same cycle -> all five outputs lock on the next edge, and in_gnt=5'b11111.
REQ-032 Reset mid-packet: assert rst while output 1 is locked to input 3 -> on the next edge out_cfg=0, in_gnt=0, and ptr for output 1 returns to 0.

Source files
------------

// File: rtl/sw_alloc_rr.sv
// 5x5 router switch allocator: one wormhole FSM per output,
// round-robin or fixed-priority pick, sticky request-error flags.
module sw_alloc_rr #(
  parameter bit ALLOW_UTURN = 1'b0,
  parameter bit RR          = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0][4:0] in_req,
  input  logic [4:0]      in_tail,
  output logic [4:0]      in_gnt,
  output logic [4:0][4:0] out_cfg,
  output logic [1:0]      err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } st_e;

  st_e             r_st [5];
  st_e             w_st_nxt [5];
  logic [4:0][4:0] r_cfg;
  logic [4:0][4:0] w_own_nxt;
  logic [4:0][4:0] w_elig;
  logic [4:0][2:0] r_ptr;
  logic [4:0][2:0] w_ptr_nxt;
  logic [4:0]      r_gnt;
  logic [4:0]      w_gnt_nxt;
  logic [4:0]      w_one;
  logic [4:0]      w_multi;
  logic [4:0]      w_uturn;
  logic [1:0]      r_err;
  logic [1:0]      w_err_nxt;

  function automatic logic [2:0] f_inc(
    input logic [2:0] x
  );
    return (x == 3'd4) ? 3'd0 : x + 3'd1;
  endfunction

  function automatic logic [2:0] f_enc(
    input logic [4:0] oh
  );
    logic [2:0] e;
    e = '0;
    for (int i = 0; i < 5; i++)
      if (oh[i]) e = 3'(i);
    return e;
  endfunction

  // first requester at or above ptr, wrapping mod 5
  function automatic logic [4:0] f_pick(
    input logic [4:0] req,
    input logic [2:0] ptr
  );
    logic [4:0] g;
    logic [2:0] idx;
    logic       hit;
    g   = '0;
    idx = ptr;
    hit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!hit && req[idx]) begin
        g[idx] = 1'b1;
        hit    = 1'b1;
      end
      idx = f_inc(idx);
    end
    return g;
  endfunction

  always_comb begin
    w_one   = '0;
    w_multi = '0;
    w_uturn = '0;
    w_elig  = '0;
    for (int p = 0; p < 5; p++) begin
      w_one[p]   = (in_req[p] != '0) &&
                   ((in_req[p] & (in_req[p] - 5'd1)) == '0);
      w_multi[p] = (in_req[p] != '0) && !w_one[p];
      w_uturn[p] = !ALLOW_UTURN && in_req[p][p];
    end
    for (int o = 0; o < 5; o++)
      for (int p = 0; p < 5; p++)
        w_elig[o][p] = in_req[p][o] && w_one[p] &&
                       !r_gnt[p] && !w_uturn[p];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) r_st[o] <= S_IDLE;
      r_cfg <= '0;
      r_ptr <= '0;
      r_gnt <= '0;
      r_err <= '0;
    end else begin
      for (int o = 0; o < 5; o++) r_st[o] <= w_st_nxt[o];
      r_cfg <= w_own_nxt;
      r_ptr <= w_ptr_nxt;
      r_gnt <= w_gnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  // a locked output never arbitrates, so release leaves one idle cycle
  always_comb begin
    w_own_nxt = r_cfg;
    w_ptr_nxt = r_ptr;
    for (int o = 0; o < 5; o++) begin
      w_st_nxt[o] = r_st[o];
      unique case (r_st[o])
        S_IDLE: begin
          if (|w_elig[o]) begin
            w_st_nxt[o]  = S_LOCK;
            w_own_nxt[o] = f_pick(w_elig[o],
                                  RR ? r_ptr[o] : 3'd0);
          end
        end
        S_LOCK: begin
          if (|(in_tail & r_cfg[o])) begin
            w_st_nxt[o]  = S_IDLE;
            w_own_nxt[o] = '0;
            if (RR)
              w_ptr_nxt[o] = f_inc(f_enc(r_cfg[o]));
          end
        end
        default: w_st_nxt[o] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_gnt_nxt = '0;
    for (int o = 0; o < 5; o++)
      w_gnt_nxt = w_gnt_nxt | w_own_nxt[o];
    w_err_nxt = r_err | {|w_multi, |w_uturn};
  end

  assign out_cfg = r_cfg;
  assign in_gnt  = r_gnt;
  assign err     = r_err;

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Directed bench for sw_alloc_rr with a queue scoreboard;
// a monitor pops one expectation after every clock edge.
module tb_sw_alloc_rr;

  logic            clk;
  logic            rst;
  logic [4:0][4:0] in_req;
  logic [4:0]      in_tail;
  logic [4:0]      in_gnt;
  logic [4:0][4:0] out_cfg;
  logic [1:0]      err;

  typedef struct {
    string           nm;
    logic [4:0][4:0] cfg;
    logic [4:0]      gnt;
    logic [1:0]      err;
  } exp_t;

  exp_t sb [$];
  int   n_vec;
  int   n_bad;

  logic [4:0][4:0] rq;
  logic [4:0]      tl;
  logic [4:0][4:0] ec;
  logic [4:0]      eg;
  logic [1:0]      ee;

  sw_alloc_rr dut (
    .clk     (clk),
    .rst     (rst),
    .in_req  (in_req),
    .in_tail (in_tail),
    .in_gnt  (in_gnt),
    .out_cfg (out_cfg),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (out_cfg !== e.cfg) begin
        n_bad++;
        $display("FAIL %s cfg got %b want %b",
                 e.nm, out_cfg, e.cfg);
      end
      if (in_gnt !== e.gnt) begin
        n_bad++;
        $display("FAIL %s gnt got %b want %b",
                 e.nm, in_gnt, e.gnt);
      end
      if (err !== e.err) begin
        n_bad++;
        $display("FAIL %s err got %b want %b",
                 e.nm, err, e.err);
      end
    end
  end

  task automatic go(input string nm, input logic r);
    exp_t e;
    rst     = r;
    in_req  = rq;
    in_tail = tl;
    e.nm    = nm;
    e.cfg   = ec;
    e.gnt   = eg;
    e.err   = ee;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    tl = '0;
  endtask

  task automatic clr_exp();
    ec = '0;
    eg = '0;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    in_req  = '0;
    in_tail = '0;
    rq = '0; tl = '0; ec = '0; eg = '0; ee = '0;
    @(negedge clk);

    go("reset0", 1'b1);
    go("reset1", 1'b1);

    // single request L->S, tail five cycles later
    rq[4] = 5'b00001;
    ec[0] = 5'b10000; eg = 5'b10000;
    go("single_grant", 1'b0);
    for (int i = 0; i < 4; i++) go("single_hold", 1'b0);
    rq = '0; tl = 5'b10000; clr_exp();
    go("single_release", 1'b0);
    go("single_idle", 1'b0);

    // RR contention on output 4 from inputs 1,2,3
    rq[1] = 5'b10000; rq[2] = 5'b10000; rq[3] = 5'b10000;
    ec[4] = 5'b00010; eg = 5'b00010;
    go("rr_grant1", 1'b0);
    go("rr_hold1", 1'b0);
    tl = 5'b00010; clr_exp();
    go("rr_bubble1", 1'b0);
    ec[4] = 5'b00100; eg = 5'b00100;
    go("rr_grant2", 1'b0);
    tl = 5'b01000;
    go("rr_stray_tail", 1'b0);
    tl = 5'b00100; clr_exp();
    go("rr_bubble2", 1'b0);
    ec[4] = 5'b01000; eg = 5'b01000;
    go("rr_grant3", 1'b0);
    tl = 5'b01000; clr_exp();
    go("rr_bubble3", 1'b0);
    rq[3] = '0;
    ec[4] = 5'b00010; eg = 5'b00010;
    go("rr_wrap_grant1", 1'b0);
    rq = '0; tl = 5'b00010; clr_exp();
    go("rr_release", 1'b0);
    go("rr_idle", 1'b0);

    // wormhole hold: input 2 on output 0 with request dropped
    rq[2] = 5'b00001;
    ec[0] = 5'b00100; eg = 5'b00100;
    go("worm_grant", 1'b0);
    rq[2] = '0; rq[1] = 5'b00001;
    for (int i = 0; i < 3; i++) go("worm_hold", 1'b0);
    tl = 5'b00100; clr_exp();
    go("worm_bubble", 1'b0);
    ec[0] = 5'b00010; eg = 5'b00010;
    go("worm_next", 1'b0);
    rq = '0; tl = 5'b00010; clr_exp();
    go("worm_release", 1'b0);

    // five parallel grants
    rq[4] = 5'b00100; rq[3] = 5'b00010; rq[2] = 5'b00001;
    rq[1] = 5'b01000; rq[0] = 5'b10000;
    ec[2] = 5'b10000; ec[1] = 5'b01000; ec[0] = 5'b00100;
    ec[3] = 5'b00010; ec[4] = 5'b00001; eg = 5'b11111;
    go("par_grant", 1'b0);
    rq = '0; tl = 5'b11111; clr_exp();
    go("par_release", 1'b0);

    // reset mid-packet; ptr of output 1 must return to 0
    rq[3] = 5'b00010;
    ec[1] = 5'b01000; eg = 5'b01000;
    go("mid_grant", 1'b0);
    rq[0] = 5'b00010; rq[4] = 5'b00010; clr_exp();
    go("mid_reset", 1'b1);
    rq[3] = '0;
    ec[1] = 5'b00001; eg = 5'b00001;
    go("mid_ptr0_grant", 1'b0);
    rq = '0; tl = 5'b00001; clr_exp();
    go("mid_release", 1'b0);

    // sticky errors
    rq[0] = 5'b00001; ee = 2'b01;
    go("err_uturn", 1'b0);
    rq = '0; rq[3] = 5'b10010; ee = 2'b11;
    go("err_multi", 1'b0);
    rq[1] = 5'b10000;
    ec[4] = 5'b00010; eg = 5'b00010;
    go("err_other_ok", 1'b0);
    rq = '0; tl = 5'b00010; clr_exp();
    go("err_sticky", 1'b0);
    go("err_sticky2", 1'b0);
    ee = 2'b00;
    go("err_reset", 1'b1);
    go("final_idle", 1'b0);

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
